// File: rtl/idli_pkg.sv
// Shared types for the idli SQI sequencer: nibble counter, transaction phases, port owner.
// Also used by the IDLI_SQ_FAIR_EN arbitration variant.
package idli_pkg;

    typedef logic [1:0] ctr_t;

    typedef enum logic [1:0] {SQ_IDLE, SQ_CMD, SQ_ADDR, SQ_DATA} sq_phase_t;

    typedef enum logic {SQ_OWN_FETCH, SQ_OWN_DATA} sq_owner_t;

    localparam ctr_t SQ_CTR_LAST = 2'd3;

endpackage

// File: rtl/idli_sqi_arb_m.sv
// Pure fetch/data arbitration for the SQI port. With IDLI_SQ_FAIR_EN defined, contention
// alternates on the last owner; otherwise data always beats fetch.
module idli_sqi_arb_m
    import idli_pkg::*;
(
    input  logic      i_fetch_req,
    input  logic      i_data_req,
    input  sq_owner_t i_last_owner,
    output sq_owner_t o_winner,
    output logic      o_any
);

    always_comb begin
        o_any    = i_fetch_req | i_data_req;
        o_winner = i_data_req ? SQ_OWN_DATA : SQ_OWN_FETCH;
`ifdef IDLI_SQ_FAIR_EN
        // Under contention the side that did not own the previous transaction goes next.
        if (i_fetch_req && i_data_req) begin
            o_winner = (i_last_owner == SQ_OWN_FETCH) ? SQ_OWN_DATA : SQ_OWN_FETCH;
        end
`endif
    end

`ifndef IDLI_SQ_FAIR_EN
    logic unused_last_owner;
    assign unused_last_owner = (i_last_owner == SQ_OWN_DATA);
`endif

endmodule

// File: rtl/idli_sqi_seq_m.sv
// SQI port sequencer: free-running nibble counter, CMD/ADDR/DATA phase FSM and owner latch.
// Arbitration policy comes from idli_sqi_arb_m (IDLI_SQ_FAIR_EN selects round-robin).
module idli_sqi_seq_m
    import idli_pkg::*;
(
    input  logic      i_sq_gck,
    input  logic      i_sq_rst,
    input  logic      i_sq_fetch_req,
    input  logic      i_sq_data_req,
    input  logic      i_sq_data_wr,
    output ctr_t      o_sq_ctr,
    output logic      o_sq_gnt_fetch,
    output logic      o_sq_gnt_data,
    output logic      o_sq_done,
    output logic      o_sq_sel,
    output sq_phase_t o_sq_phase,
    output logic      o_sq_mem_cs,
    output logic      o_sq_mem_wr,
    output logic      o_sq_mem_oe,
    output logic      o_sq_enc_vld,
    output logic      o_sq_ld_vld
);

    // Handshake: a requester holds req until its one-cycle gnt pulse (CMD, ctr==0) and must
    // drop it on the following cycle; req still high after that is a fresh request.

    ctr_t      ctr_q;
    sq_phase_t phase_q;
    sq_phase_t phase_d;
    sq_owner_t owner_q;
    logic      wr_q;
    sq_owner_t arb_winner;
    logic      arb_any;
    logic      arb_slot;
    logic      arb_take;

    idli_sqi_arb_m u_arb (
        .i_fetch_req  (i_sq_fetch_req),
        .i_data_req   (i_sq_data_req),
        .i_last_owner (owner_q),
        .o_winner     (arb_winner),
        .o_any        (arb_any)
    );

    // The port can change hands only at the end of a word while idle or finishing DATA.
    assign arb_slot = (ctr_q == SQ_CTR_LAST) && ((phase_q == SQ_IDLE) || (phase_q == SQ_DATA));
    assign arb_take = arb_slot && arb_any;

    always_comb begin
        phase_d = phase_q;
        if (ctr_q == SQ_CTR_LAST) begin
            case (phase_q)
                SQ_IDLE: phase_d = arb_any ? SQ_CMD : SQ_IDLE;
                SQ_CMD:  phase_d = SQ_ADDR;
                SQ_ADDR: phase_d = SQ_DATA;
                SQ_DATA: phase_d = arb_any ? SQ_CMD : SQ_IDLE;
                default: phase_d = SQ_IDLE;
            endcase
        end
    end

    // The owner register doubles as the fairness last-owner bit.
    always_ff @(posedge i_sq_gck) begin
        if (i_sq_rst) begin
            ctr_q   <= '0;
            phase_q <= SQ_IDLE;
            owner_q <= SQ_OWN_FETCH;
            wr_q    <= 1'b0;
        end else begin
            ctr_q   <= ctr_q + 2'd1;
            phase_q <= phase_d;
            if (arb_take) begin
                owner_q <= arb_winner;
                wr_q    <= (arb_winner == SQ_OWN_DATA) && i_sq_data_wr;
            end
        end
    end

    assign o_sq_ctr       = ctr_q;
    assign o_sq_phase     = phase_q;
    assign o_sq_sel       = (owner_q == SQ_OWN_DATA);
    assign o_sq_gnt_fetch = (phase_q == SQ_CMD) && (ctr_q == '0) && (owner_q == SQ_OWN_FETCH);
    assign o_sq_gnt_data  = (phase_q == SQ_CMD) && (ctr_q == '0) && (owner_q == SQ_OWN_DATA);
    assign o_sq_done      = (phase_q == SQ_DATA) && (ctr_q == SQ_CTR_LAST);
    assign o_sq_mem_cs    = (phase_q != SQ_IDLE);
    assign o_sq_mem_wr    = o_sq_mem_cs && wr_q;
    assign o_sq_mem_oe    = (phase_q == SQ_CMD) || (phase_q == SQ_ADDR) ||
                            ((phase_q == SQ_DATA) && wr_q);
    assign o_sq_enc_vld   = (phase_q == SQ_DATA) && !wr_q && (owner_q == SQ_OWN_FETCH);
    assign o_sq_ld_vld    = (phase_q == SQ_DATA) && !wr_q && (owner_q == SQ_OWN_DATA);

endmodule

// File: tb/tb_idli_sqi_seq_m.sv
// Bench for idli_sqi_seq_m: transaction-level model compared every cycle plus directed checks.
// Contention expectations follow IDLI_SQ_FAIR_EN.
module tb_idli_sqi_seq_m;
    import idli_pkg::*;

    logic      clk;
    logic      rst;
    logic      fetch_req;
    logic      data_req;
    logic      data_wr;
    ctr_t      sq_ctr;
    logic      gnt_fetch;
    logic      gnt_data;
    logic      done;
    logic      sel;
    sq_phase_t phase;
    logic      cs;
    logic      mem_wr;
    logic      oe;
    logic      enc_vld;
    logic      ld_vld;

    int tests_run = 0;
    int tests_failed = 0;

    idli_sqi_seq_m dut (
        .i_sq_gck       (clk),
        .i_sq_rst       (rst),
        .i_sq_fetch_req (fetch_req),
        .i_sq_data_req  (data_req),
        .i_sq_data_wr   (data_wr),
        .o_sq_ctr       (sq_ctr),
        .o_sq_gnt_fetch (gnt_fetch),
        .o_sq_gnt_data  (gnt_data),
        .o_sq_done      (done),
        .o_sq_sel       (sel),
        .o_sq_phase     (phase),
        .o_sq_mem_cs    (cs),
        .o_sq_mem_wr    (mem_wr),
        .o_sq_mem_oe    (oe),
        .o_sq_enc_vld   (enc_vld),
        .o_sq_ld_vld    (ld_vld)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Time is counted in cycles since reset; a transaction is a 12-cycle window
    // starting at its grant cycle, and everything is derived from the offset into it.
    int cyc;
    int tx_start;
    bit tx_act;
    bit m_owner;      // 1 = data
    bit m_wr;
    bit last_own;
    bit model_ok = 1'b0;

    function automatic bit pick(input bit f, input bit d, input bit last);
`ifdef IDLI_SQ_FAIR_EN
        if (f && d) return !last;
`endif
        return d;
    endfunction

    always @(posedge clk) begin
        int off;
        bit win;
        if (rst) begin
            cyc = 0; tx_act = 0; tx_start = 0;
            m_owner = 0; m_wr = 0; last_own = 0;
            model_ok = 1'b1;
        end else begin
            off = cyc - tx_start;
            if ((cyc % 4 == 3) && (!tx_act || off == 11) && (fetch_req || data_req)) begin
                win      = pick(fetch_req, data_req, last_own);
                tx_start = cyc + 1;
                tx_act   = 1;
                m_owner  = win;
                m_wr     = win && data_wr;
                last_own = win;
            end else if (tx_act && off == 11) begin
                tx_act = 0;
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int off;
        bit in_tx;
        if (model_ok) begin
            off   = cyc - tx_start;
            in_tx = tx_act;
            chk("ctr",       int'(sq_ctr),    cyc % 4);
            chk("phase",     int'(phase),     in_tx ? 1 + off / 4 : 0);
            chk("gnt_fetch", int'(gnt_fetch), int'(in_tx && off == 0 && !m_owner));
            chk("gnt_data",  int'(gnt_data),  int'(in_tx && off == 0 && m_owner));
            chk("done",      int'(done),      int'(in_tx && off == 11));
            chk("sel",       int'(sel),       int'(m_owner));
            chk("cs",        int'(cs),        int'(in_tx));
            chk("mem_wr",    int'(mem_wr),    int'(in_tx && m_wr));
            chk("oe",        int'(oe),        int'(in_tx && (off < 8 || m_wr)));
            chk("enc_vld",   int'(enc_vld),   int'(in_tx && off >= 8 && !m_wr && !m_owner));
            chk("ld_vld",    int'(ld_vld),    int'(in_tx && off >= 8 && !m_wr && m_owner));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_ctr(input int k);
        for (int i = 0; i < 4 && (cyc % 4) != k; i++) step();
    endtask

    // ---------------- directed stimulus ----------------
    int lat, cs_cnt, enc_cnt, enc_first, done_at, oe_cnt, wr_cnt, ld_cnt, gap, n, guard;
    int g[3];
    bit prev_sel;

    initial begin
        rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
        step(); step();
        rst = 1'b0;

        // Idle after reset: counter walks 0..3, nothing else moves.
        for (int i = 0; i < 8; i++) begin
            chk("idle_ctr", int'(sq_ctr), i % 4);
            chk("idle_cs", int'(cs), 0);
            chk("idle_gnt", int'(gnt_fetch | gnt_data), 0);
            step();
        end

        // Fetch request seen at ctr==3: grant one cycle later, 12-cycle read.
        wait_ctr(3);
        fetch_req = 1'b1;
        step();
        chk("fetch_gnt_lat1", int'(gnt_fetch), 1);
        fetch_req = 1'b0;
        cs_cnt = 0; enc_cnt = 0; enc_first = -1; done_at = -1;
        for (int i = 0; i < 12; i++) begin
            cs_cnt += int'(cs);
            enc_cnt += int'(enc_vld);
            if (enc_vld && enc_first < 0) enc_first = i;
            if (done) done_at = i;
            step();
        end
        chk("fetch_cs_cycles", cs_cnt, 12);
        chk("fetch_enc_cycles", enc_cnt, 4);
        chk("fetch_enc_first", enc_first, 8);
        chk("fetch_done_cycle", done_at, 11);
        chk("fetch_then_idle", int'(cs), 0);

        // Store request seen at ctr==1: grant three cycles later.
        wait_ctr(1);
        data_req = 1'b1; data_wr = 1'b1;
        lat = 0;
        while (!gnt_data && lat < 10) begin step(); lat++; end
        chk("store_gnt_lat3", lat, 3);
        data_req = 1'b0; data_wr = 1'b0;
        oe_cnt = 0; wr_cnt = 0; ld_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            oe_cnt += int'(oe);
            wr_cnt += int'(mem_wr);
            ld_cnt += int'(ld_vld);
            step();
        end
        chk("store_oe_cycles", oe_cnt, 12);
        chk("store_wr_cycles", wr_cnt, 12);
        chk("store_ld_cycles", ld_cnt, 0);

        // Data read followed back-to-back by a fetch still pending at DATA ctr==3.
        data_req = 1'b1;
        guard = 0;
        while (!gnt_data && guard < 10) begin step(); guard++; end
        chk("b2b_data_gnt", int'(gnt_data), 1);
        data_req = 1'b0;
        fetch_req = 1'b1;
        lat = 0; gap = 0; ld_cnt = 0; prev_sel = 1'b0;
        while (!gnt_fetch && lat < 20) begin
            prev_sel = sel;
            step();
            lat++;
            if (!cs) gap++;
            ld_cnt += int'(ld_vld);
        end
        fetch_req = 1'b0;
        chk("b2b_gnt_spacing", lat, 12);
        chk("b2b_cs_gap", gap, 0);
        chk("b2b_ld_cycles", ld_cnt, 4);
        chk("b2b_sel_before", int'(prev_sel), 1);
        chk("b2b_sel_at_gnt", int'(sel), 0);

        // Reset in the middle of the fetch's DATA phase.
        for (int i = 0; i < 9; i++) step();
        chk("mid_data_phase", int'(phase), 3);
        rst = 1'b1;
        step();
        chk("rst_phase", int'(phase), 0);
        chk("rst_cs", int'(cs), 0);
        chk("rst_ctr", int'(sq_ctr), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sel", int'(sel), 0);
        rst = 1'b0;

        // Both requesters hold continuously for three transactions.
        fetch_req = 1'b1; data_req = 1'b1;
        n = 0; guard = 0;
        while (n < 3 && guard < 80) begin
            step();
            guard++;
            if (gnt_data) begin g[n] = 1; n++; end
            else if (gnt_fetch) begin g[n] = 0; n++; end
        end
        fetch_req = 1'b0; data_req = 1'b0;
        chk("contend_grants", n, 3);
        chk("contend_gnt0", g[0], 1);
`ifdef IDLI_SQ_FAIR_EN
        chk("contend_gnt1", g[1], 0);
`else
        chk("contend_gnt1", g[1], 1);
`endif
        chk("contend_gnt2", g[2], 1);
        guard = 0;
        while (cs && guard < 20) begin step(); guard++; end
        chk("contend_drain", int'(cs), 0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        tests_failed++;
        $display("FAIL watchdog: bench did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/idli_sqi_seq_m.md
# idli_sqi_seq_m

Sequencer and arbiter for the single SQI memory port shared by instruction fetch and execute-stage load/store. It owns the free-running nibble sync counter that the execution unit and decoder consume. It frames each memory transaction as three word-aligned phases: command, address and data. It grants the port to exactly one requester per transaction and qualifies returning read nibbles as instruction encodings or load data.

## Interface

Parameters: none. All widths come from `idli_pkg`.

Ports:
- `i_sq_gck`  in  1  clock.
- `i_sq_rst`  in  1  reset; synchronous, active-high.
- `i_sq_fetch_req`  in  1  fetch wants a transaction; always a read; held until granted.
- `i_sq_data_req`  in  1  execute stage wants a transaction; held until granted.
- `i_sq_data_wr`  in  1  data transaction is a store; sampled with `i_sq_data_req`.
- `o_sq_ctr`  out  `ctr_t`  nibble counter, 0..3; 0 marks word start.
- `o_sq_gnt_fetch`  out  1  one-cycle grant pulse to fetch.
- `o_sq_gnt_data`  out  1  one-cycle grant pulse to data.
- `o_sq_done`  out  1  pulse on the last nibble of the DATA phase.
- `o_sq_sel`  out  1  current owner; 0 = fetch, 1 = data. Selects the address/data mux outside this block.
- `o_sq_phase`  out  `sq_phase_t`  current phase.
- `o_sq_mem_cs`  out  1  SQI chip select, active-high.
- `o_sq_mem_wr`  out  1  transaction is a write; valid while `cs` is high.
- `o_sq_mem_oe`  out  1  port drives SQI data lines.
- `o_sq_enc_vld`  out  1  SQI read nibble is an instruction encoding; feeds `i_ex_enc_vld`.
- `o_sq_ld_vld`  out  1  SQI read nibble is load data.

## Operation

- Counter:
  - Increments every cycle and wraps 3 -> 0.
  - Free-running regardless of phase.
- Phase FSM: IDLE -> CMD -> ADDR -> DATA -> (CMD | IDLE).
  - Each non-IDLE phase lasts exactly 4 cycles, ctr 0..3.
  - Transitions happen only on the ctr==3 -> 0 edge.
- Arbitration:
  - Evaluated in the cycle where ctr==3 and phase is IDLE or DATA.
  - If any request is asserted (and not being granted this cycle), the next phase is CMD. Otherwise it is IDLE.
  - The winner's grant pulses in the first CMD cycle (ctr==0).
  - `o_sq_sel`, `o_sq_mem_wr` and the owner are latched there and held through DATA.
- A request asserted on the same cycle its grant pulses is the held request and is consumed. The requester must drop `req` the cycle after `gnt`. Otherwise a new transaction is requested.
- Default priority: data wins over fetch when both are asserted.
- `o_sq_mem_cs` is high in CMD, ADDR and DATA; low in IDLE.
- `o_sq_mem_oe`:
  - High in CMD and ADDR.
  - In DATA, high only for writes.
- DATA phase of a read:
  - `o_sq_enc_vld` = (owner == fetch).
  - `o_sq_ld_vld` = (owner == data).
  - Both are low otherwise.
- `o_sq_done` is high for DATA with ctr==3.
- Back-to-back transactions:
  - If a request is pending at DATA ctr==3, CMD starts the next cycle.
  - `cs` stays high with no IDLE gap.

## Timing

- Reset value of every output:
  - `ctr` = 0.
  - Phase = IDLE.
  - `gnt_*`, `done`, `cs`, `wr`, `oe`, `enc_vld` and `ld_vld` = 0.
  - `sel` = 0.
  - Fairness state is cleared.
- Reset asserted mid-transaction: the next cycle is the reset state. The transaction is abandoned with no `done`. Requesters re-request.
- Grant latency from IDLE: a request first seen at ctr==k gets its grant 4−k cycles later; ctr==3 gives 1 cycle, ctr==0 gives 4 cycles.
- Transaction length: 12 cycles from grant to the cycle after `done`.
- All outputs are registered or decoded from registered state only. There is no combinational path from any `req` to any output.

## Configuration

- `IDLI_SQ_FAIR_EN` defined: one-bit last-owner round-robin.
  - When both requests are asserted, the requester that did not win the previous transaction wins.
  - The last-owner bit resets to fetch, so data wins the first contention.
- `IDLI_SQ_FAIR_EN` undefined: strict data priority. Fetch can starve under continuous data requests.

## Structure

- `idli_pkg` gains:
  - `typedef enum logic [1:0] sq_phase_t {SQ_IDLE, SQ_CMD, SQ_ADDR, SQ_DATA}`.
  - `typedef enum logic sq_owner_t {SQ_OWN_FETCH, SQ_OWN_DATA}`.
  - `SQ_CTR_LAST = 2'd3`.
- One sub-module, `idli_sqi_arb_m`:
  - Pure arbitration: requests, last owner and `IDLI_SQ_FAIR_EN` in; winner out.
- The parent holds the counter, FSM and owner/write latches.

## Test plan

- Reset, then idle for 8 cycles. `ctr` cycles 0,1,2,3,0 and all other outputs stay 0. Assert `rst` mid-DATA: next cycle phase = IDLE, `cs` = 0, `ctr` = 0.
- `fetch_req` at ctr==3 -> `gnt_fetch` next cycle. `cs` high 12 cycles. `enc_vld` high exactly on DATA ctr 0..3. `done` on the 12th cycle.
- `data_req` + `data_wr` at ctr==1 -> `gnt_data` 3 cycles later. `oe` high all 12 cycles, `wr` = 1, `ld_vld` never high.
- Both requests held continuously for 3 transactions:
  - Without the macro: grants are data, data, data.
  - With `IDLI_SQ_FAIR_EN`: grants are data, fetch, data.
- Fetch request still asserted at DATA ctr==3 of a data read: CMD follows with no IDLE cycle, `cs` stays high, `sel` changes 1 -> 0 on the grant cycle.
